// File: rtl/psg_pkg.sv
// Shared constants for the PSG register interface: latch register codes
// {channel[1:0], type} and the attenuation "off" value.
package psg_pkg;

    localparam logic [2:0] REG_TONE0 = 3'b000;
    localparam logic [2:0] REG_ATTN0 = 3'b001;
    localparam logic [2:0] REG_TONE1 = 3'b010;
    localparam logic [2:0] REG_ATTN1 = 3'b011;
    localparam logic [2:0] REG_TONE2 = 3'b100;
    localparam logic [2:0] REG_ATTN2 = 3'b101;
    localparam logic [2:0] REG_NOISE = 3'b110;
    localparam logic [2:0] REG_ATTN3 = 3'b111;

    localparam logic [3:0] ATTN_OFF  = 4'hF;
    localparam int         LATCH_BIT = 7;

endpackage

// File: rtl/psg_strobe_sync.sv
// Synchronises the asynchronous we_n strobe and emits a one-cycle pulse on its
// falling edge. A strobe already low when reset releases never produces a pulse.
module psg_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic we_n,
    output logic fall_pulse
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   sync_out;
    logic                   filled;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], we_n};
        sync_out   = sync_q[SYNC_STAGES-1];
        filled     = (fill_q == FILL_W'(SYNC_STAGES));
        fill_d     = filled ? fill_q : fill_q + FILL_W'(1);
        prev_d     = sync_out;
        // Arm only once the chain holds real samples and has seen we_n high.
        armed_d    = armed_q | (filled & sync_out);
        fall_pulse = armed_q & prev_q & ~sync_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            fill_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/psg_register_interface.sv
// Bus-side write decoder and register file for an SN76489-compatible PSG:
// latch/data byte protocol, channel state, ready throttle and LFSR-reset pulse.
module psg_register_interface
    import psg_pkg::*;
#(
    parameter int COUNTER_BITS = 10,
    parameter int READY_CYCLES = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              data,
    input  logic                    we_n,
    output logic                    ready,
    output logic [COUNTER_BITS-1:0] tone_freq0,
    output logic [COUNTER_BITS-1:0] tone_freq1,
    output logic [COUNTER_BITS-1:0] tone_freq2,
    output logic [3:0]              attn0,
    output logic [3:0]              attn1,
    output logic [3:0]              attn2,
    output logic [3:0]              attn3,
    output logic [2:0]              noise_ctrl,
    output logic                    reset_lfsr
);

    localparam int CNT_W = $clog2(READY_CYCLES + 1);

    logic                    fall_pulse;
    logic                    accept;
    logic [2:0]              target;

    logic [COUNTER_BITS-1:0] tone_q [3];
    logic [COUNTER_BITS-1:0] tone_d [3];
    logic [3:0]              attn_q [4];
    logic [3:0]              attn_d [4];
    logic [2:0]              noise_q, noise_d;
    logic [2:0]              latched_q, latched_d;
    logic [CNT_W-1:0]        busy_q, busy_d;
    logic                    lfsr_q, lfsr_d;

    psg_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_strobe_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .we_n      (we_n),
        .fall_pulse(fall_pulse)
    );

    assign ready  = (busy_q == '0);
    assign accept = fall_pulse & ready;
    // A latch byte addresses its own register; a data byte uses the last latch.
    assign target = data[LATCH_BIT] ? data[6:4] : latched_q;

    always_comb begin
        tone_d    = tone_q;
        attn_d    = attn_q;
        noise_d   = noise_q;
        latched_d = latched_q;
        lfsr_d    = 1'b0;
        busy_d    = (busy_q != '0) ? busy_q - CNT_W'(1) : busy_q;

        if (accept) begin
            busy_d = CNT_W'(READY_CYCLES);
            if (data[LATCH_BIT]) begin
                latched_d = data[6:4];
            end
            if (target[0]) begin
                for (int i = 0; i < 4; i++) begin
                    if (target[2:1] == 2'(i)) begin
                        attn_d[i] = data[3:0];
                    end
                end
            end else if (target == REG_NOISE) begin
                noise_d = data[2:0];
                lfsr_d  = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (target[2:1] == 2'(i)) begin
                        if (data[LATCH_BIT]) begin
                            tone_d[i][3:0] = data[3:0];
                        end else begin
                            tone_d[i][COUNTER_BITS-1:4] = data[COUNTER_BITS-5:0];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                tone_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                attn_q[i] <= ATTN_OFF;
            end
            noise_q   <= '0;
            latched_q <= REG_TONE0;
            busy_q    <= '0;
            lfsr_q    <= 1'b0;
        end else begin
            tone_q    <= tone_d;
            attn_q    <= attn_d;
            noise_q   <= noise_d;
            latched_q <= latched_d;
            busy_q    <= busy_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign tone_freq0 = tone_q[0];
    assign tone_freq1 = tone_q[1];
    assign tone_freq2 = tone_q[2];
    assign attn0      = attn_q[0];
    assign attn1      = attn_q[1];
    assign attn2      = attn_q[2];
    assign attn3      = attn_q[3];
    assign noise_ctrl = noise_q;
    assign reset_lfsr = lfsr_q;

endmodule

// File: tb/tb_psg_register_interface.sv
// Scoreboard bench for psg_register_interface: stimulus queues the expected
// register snapshot per write; a monitor checks it when ready drops.
module tb_psg_register_interface;

    typedef struct packed {
        logic [9:0] t0;
        logic [9:0] t1;
        logic [9:0] t2;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] a3;
        logic [2:0] nc;
        logic       lf;
    } snap_t;

    localparam snap_t RST = '{t0: 10'h0, t1: 10'h0, t2: 10'h0,
                              a0: 4'hF, a1: 4'hF, a2: 4'hF, a3: 4'hF,
                              nc: 3'h0, lf: 1'b0};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       we_n = 1'b1;
    logic       ready;
    logic [9:0] tone_freq0, tone_freq1, tone_freq2;
    logic [3:0] attn0, attn1, attn2, attn3;
    logic [2:0] noise_ctrl;
    logic       reset_lfsr;

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t exp_q[$];
    snap_t exp_s;
    snap_t dut_s;

    psg_register_interface #(
        .COUNTER_BITS(10),
        .READY_CYCLES(32),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data      (data),
        .we_n      (we_n),
        .ready     (ready),
        .tone_freq0(tone_freq0),
        .tone_freq1(tone_freq1),
        .tone_freq2(tone_freq2),
        .attn0     (attn0),
        .attn1     (attn1),
        .attn2     (attn2),
        .attn3     (attn3),
        .noise_ctrl(noise_ctrl),
        .reset_lfsr(reset_lfsr)
    );

    always #5 clk = ~clk;

    assign dut_s = '{t0: tone_freq0, t1: tone_freq1, t2: tone_freq2,
                     a0: attn0, a1: attn1, a2: attn2, a3: attn3,
                     nc: noise_ctrl, lf: reset_lfsr};

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Snapshot fields printed as t0_t1_t2_a0a1a2a3_nc_lf.
    task automatic check_snap(input string name, input snap_t act, input snap_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h_%h_%h_%h%h%h%h_%h_%b, expected %h_%h_%h_%h%h%h%h_%h_%b",
                     name, act.t0, act.t1, act.t2, act.a0, act.a1, act.a2, act.a3, act.nc, act.lf,
                     req.t0, req.t1, req.t2, req.a0, req.a1, req.a2, req.a3, req.nc, req.lf);
        end
    endtask

    // Monitor: ready falling marks cycle E+1 of an accepted write.
    logic prev_ready = 1'b1;
    logic busy       = 1'b0;
    logic just_fell  = 1'b0;
    int   low_cnt    = 0;
    int   txn        = 0;
    snap_t got_exp;

    always @(negedge clk) begin
        if (!reset_n) begin
            busy       = 1'b0;
            prev_ready = 1'b1;
            just_fell  = 1'b0;
        end else begin
            just_fell = prev_ready && !ready;
            if (just_fell) begin
                txn++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b0, 64'(dut_s.lf), 64'(0));
                end else begin
                    got_exp = exp_q.pop_front();
                    check_snap($sformatf("write%0d_state", txn), dut_s, got_exp);
                    $display("txn %0d: t0=%h t1=%h t2=%h attn=%h%h%h%h noise=%b lfsr=%b",
                             txn, tone_freq0, tone_freq1, tone_freq2,
                             attn0, attn1, attn2, attn3, noise_ctrl, reset_lfsr);
                end
                busy    = 1'b1;
                low_cnt = 1;
            end else begin
                check("lfsr_spurious", !reset_lfsr, 64'(reset_lfsr), 64'(0));
                if (busy) begin
                    if (!ready) begin
                        low_cnt++;
                    end else begin
                        check($sformatf("write%0d_ready_low_cycles", txn),
                              low_cnt == 32, 64'(low_cnt), 64'(32));
                        busy = 1'b0;
                    end
                end
            end
            prev_ready = ready;
        end
    end

    task automatic strobe(input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        data = d;
        we_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        we_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        while (!ready && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 1'b0, 64'(ready), 64'(1));
        repeat (3) @(posedge clk);
    endtask

    task automatic write(input logic [7:0] d, input snap_t e);
        exp_q.push_back(e);
        strobe(d, 6);
        wait_idle();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_s = RST;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        // Reset state
        check_snap("reset_state", dut_s, RST);
        check("reset_ready", ready === 1'b1, 64'(ready), 64'(1));

        // Tone ch0: latch low nibble E, data upper 0F
        exp_s.t0 = 10'h00E;               write(8'h8E, exp_s);
        exp_s.t0 = 10'h0FE;               write(8'h0F, exp_s);

        // Noise: latch then data byte, each pulses reset_lfsr
        exp_s.nc = 3'b101; exp_s.lf = 1'b1; write(8'hE5, exp_s);
        exp_s.nc = 3'b011;                  write(8'h03, exp_s);
        exp_s.lf = 1'b0;

        // Attenuation ch2: latch 7, then data byte A
        exp_s.a2 = 4'h7;                  write(8'hD7, exp_s);
        exp_s.a2 = 4'hA;                  write(8'h0A, exp_s);

        // Tone ch1 latch, second strobe 5 cycles later must be dropped
        exp_s.t1 = 10'h001;
        exp_q.push_back(exp_s);
        strobe(8'hA1, 4);
        strobe(8'h3F, 4);
        wait_idle();

        // Next snapshot also proves tone_freq1[9:4] stayed 0
        exp_s.a0 = 4'hC;                  write(8'h9C, exp_s);

        // Reset in the middle of a busy window
        exp_s.t0 = 10'h0F5;
        exp_q.push_back(exp_s);
        strobe(8'h85, 6);
        repeat (7) @(posedge clk);
        #2;
        check("busy_before_reset", ready === 1'b0, 64'(ready), 64'(0));
        reset_n = 1'b0;
        we_n    = 1'b0;
        #1;
        check_snap("midbusy_reset_state", dut_s, RST);
        check("midbusy_reset_ready", ready === 1'b1, 64'(ready), 64'(1));
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        // we_n held low through release must not write
        repeat (10) @(posedge clk);
        #1;
        check("held_strobe_ready", ready === 1'b1, 64'(ready), 64'(1));
        check_snap("held_strobe_state", dut_s, RST);
        we_n = 1'b1;
        repeat (5) @(posedge clk);

        // latched register back to ch0 tone: data byte hits tone_freq0[9:4]
        exp_s = RST;
        exp_s.t0 = 10'h010;               write(8'h01, exp_s);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
